hdbn_encoder: RTL

HDBN_ENCODER -- requirements
Module: hdbn_encoder

---
 rtl/hdbn_pkg.sv | 23 ++
 rtl/hdbn_polarity.sv | 48 ++++
 rtl/hdbn_encoder.sv | 92 +++++++++
 3 files changed

// File: rtl/hdbn_pkg.sv
// Shared types and constants for the HDBn line encoder.
package hdbn_pkg;

  localparam int ZERO_RUN_DEF = 3;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    MARK   = 2'd1,
    BPULSE = 2'd2,
    VPULSE = 2'd3
  } sym_e;

  typedef struct packed {
    logic vld;
    sym_e sym;
  } slot_t;

  // MARK and BPULSE alternate polarity; VPULSE repeats it on purpose.
  function automatic logic flips_polarity(input sym_e s);
    return (s == MARK) || (s == BPULSE);
  endfunction

endpackage

// File: rtl/hdbn_polarity.sv
// Output stage: maps delay-line symbols to registered BP/BN pulses with alternate-mark polarity.
module hdbn_polarity
  import hdbn_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  sym_e symbol,
  input  logic valid,
  output logic BP,
  output logic BN,
  output logic dout_vld
);

  logic last_pos_q, last_pos_d;
  logic pos_d, neg_d;

  always_comb begin
    pos_d      = 1'b0;
    neg_d      = 1'b0;
    last_pos_d = last_pos_q;
    if (valid) begin
      if (flips_polarity(symbol)) begin
        pos_d      = ~last_pos_q;
        neg_d      = last_pos_q;
        last_pos_d = ~last_pos_q;
      end else if (symbol == VPULSE) begin
        // Violation: same polarity as the previous pulse, polarity memory unchanged.
        pos_d = last_pos_q;
        neg_d = ~last_pos_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BP         <= 1'b0;
      BN         <= 1'b0;
      dout_vld   <= 1'b0;
      last_pos_q <= 1'b0;
    end else begin
      BP         <= pos_d;
      BN         <= neg_d;
      dout_vld   <= valid;
      last_pos_q <= last_pos_d;
    end
  end

endmodule

// File: rtl/hdbn_encoder.sv
// HDBn encoder (HDB3 for ZERO_RUN=3). Optional macro HDBN_AMI_MODE_EN adds an
// ami_mode input that disables zero substitution (plain AMI).
module hdbn_encoder
  import hdbn_pkg::*;
#(
  parameter int ZERO_RUN = ZERO_RUN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_vld,
  input  logic data_m,
`ifdef HDBN_AMI_MODE_EN
  input  logic ami_mode,
`endif
  output logic dout_vld,
  output logic BP,
  output logic BN
);

  // Handshake: din_vld=1 accepts data_m this cycle (no backpressure);
  // dout_vld=1 marks BP/BN as one line symbol, otherwise BP=BN=0.

  localparam int CW = $clog2(ZERO_RUN + 2);

  slot_t [ZERO_RUN:0] slots_q, slots_d;
  logic [CW-1:0]      zero_cnt_q, zero_cnt_d;
  logic               parity_q, parity_d;
  logic               sub_en;
  logic               emit_vld;

`ifdef HDBN_AMI_MODE_EN
  assign sub_en = ~ami_mode;
`else
  assign sub_en = 1'b1;
`endif

  // Slot 0 is newest; slot ZERO_RUN is handed to the output stage on each accept.
  always_comb begin
    slots_d    = slots_q;
    zero_cnt_d = zero_cnt_q;
    parity_d   = parity_q;
    if (din_vld) begin
      for (int i = ZERO_RUN; i > 0; i--) begin
        slots_d[i] = slots_q[i-1];
      end
      slots_d[0].vld = 1'b1;
      slots_d[0].sym = data_m ? MARK : ZERO;
      if (!sub_en) begin
        zero_cnt_d = '0;
        parity_d   = 1'b0;
      end else if (data_m) begin
        zero_cnt_d = '0;
        parity_d   = ~parity_q;
      end else if (zero_cnt_q == CW'(ZERO_RUN)) begin
        // After the shift, slot ZERO_RUN holds the first zero of this run.
        slots_d[0].sym = VPULSE;
        if (!parity_q) begin
          slots_d[ZERO_RUN].sym = BPULSE;
        end
        zero_cnt_d = '0;
        parity_d   = 1'b0;
      end else begin
        zero_cnt_d = zero_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q    <= '0;
      zero_cnt_q <= '0;
      parity_q   <= 1'b0;
    end else begin
      slots_q    <= slots_d;
      zero_cnt_q <= zero_cnt_d;
      parity_q   <= parity_d;
    end
  end

  assign emit_vld = din_vld & slots_q[ZERO_RUN].vld;

  hdbn_polarity u_polarity (
    .clk      (clk),
    .rst_n    (rst_n),
    .symbol   (slots_q[ZERO_RUN].sym),
    .valid    (emit_vld),
    .BP       (BP),
    .BN       (BN),
    .dout_vld (dout_vld)
  );

endmodule
